// File: rtl/branch_predictor.sv
// Bimodal / gshare branch predictor: a table of saturating counters indexed by PC
// (optionally XORed with global history), with checkpoint-based history repair and statistics.
module branch_predictor #(
    parameter int PHT_IDX_W = 6,
    parameter int CNT_W     = 2,
    parameter int GHR_W     = 0,
    localparam int GW       = (GHR_W > 0) ? GHR_W : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   pcD,
    input  logic          branchD,
    input  logic          stallD,
    output logic          pred_takeD,
    output logic [GW-1:0] pred_ghrD,
    input  logic          upd_en,
    input  logic [31:0]   upd_pc,
    input  logic          upd_taken,
    input  logic          upd_mispred,
    input  logic [GW-1:0] upd_ghr,
    output logic [31:0]   stat_branches,
    output logic [31:0]   stat_mispred
);

    localparam int PHT_N = 1 << PHT_IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

    logic [CNT_W-1:0]     r_pht [PHT_N];
    logic [31:0]          r_stat_br;
    logic [31:0]          r_stat_mp;
    logic [GW-1:0]        w_ghr;
    logic [PHT_IDX_W-1:0] w_lu_hist;
    logic [PHT_IDX_W-1:0] w_upd_hist;
    logic [PHT_IDX_W-1:0] w_lu_idx;
    logic [PHT_IDX_W-1:0] w_upd_idx;
    logic [CNT_W-1:0]     w_upd_cnt;
    logic [CNT_W-1:0]     w_upd_next;
    logic                 w_repair;

    // Address bits outside the index window never influence the table.
    logic w_unused_bits;
    assign w_unused_bits = ^{pcD[31:PHT_IDX_W+2], pcD[1:0],
                             upd_pc[31:PHT_IDX_W+2], upd_pc[1:0], upd_ghr, stallD};

    assign w_lu_hist  = (GHR_W > 0) ? PHT_IDX_W'(w_ghr)   : '0;
    assign w_upd_hist = (GHR_W > 0) ? PHT_IDX_W'(upd_ghr) : '0;
    assign w_lu_idx   = pcD[PHT_IDX_W+1:2] ^ w_lu_hist;
    assign w_upd_idx  = upd_pc[PHT_IDX_W+1:2] ^ w_upd_hist;
    assign w_repair   = upd_en & upd_mispred;

    // Lookup reads the registered table, so a same-cycle update is not visible yet.
    assign pred_takeD = branchD & r_pht[w_lu_idx][CNT_W-1];
    assign pred_ghrD  = w_ghr;

    assign w_upd_cnt = r_pht[w_upd_idx];
    always_comb begin
        w_upd_next = w_upd_cnt;
        if (upd_taken) begin
            if (w_upd_cnt != CNT_MAX) w_upd_next = w_upd_cnt + 1'b1;
        end else begin
            if (w_upd_cnt != '0) w_upd_next = w_upd_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PHT_N; i++) r_pht[i] <= CNT_WNT;
        end else if (upd_en) begin
            r_pht[w_upd_idx] <= w_upd_next;
        end
    end

    generate
        if (GHR_W > 0) begin : g_gshare
            logic [GW-1:0] r_ghr;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ghr <= '0;
                end else if (w_repair) begin
                    // Repair from the checkpoint wins over any speculative shift.
                    r_ghr <= GW'({upd_ghr, upd_taken});
                end else if (branchD && !stallD) begin
                    r_ghr <= GW'({r_ghr, pred_takeD});
                end
            end
            assign w_ghr = r_ghr;
        end else begin : g_bimodal
            assign w_ghr = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br <= '0;
            r_stat_mp <= '0;
        end else begin
            if (upd_en && (r_stat_br != 32'hFFFF_FFFF)) r_stat_br <= r_stat_br + 32'd1;
            if (w_repair && (r_stat_mp != 32'hFFFF_FFFF)) r_stat_mp <= r_stat_mp + 32'd1;
        end
    end

    assign stat_branches = r_stat_br;
    assign stat_mispred  = r_stat_mp;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: one bimodal and one gshare (GHR_W=4) instance
// share the stimulus; each scenario task checks the instance it targets.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pcD;
    logic        branchD;
    logic        stallD;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispred;
    logic [3:0]  upd_ghr;

    logic        b_pred;
    logic [0:0]  b_ghr;
    logic [31:0] b_stat_br;
    logic [31:0] b_stat_mp;
    logic        g_pred;
    logic [3:0]  g_ghr;
    logic [31:0] g_stat_br;
    logic [31:0] g_stat_mp;

    int n_tests;
    int n_fail;

    branch_predictor #(.PHT_IDX_W(6), .CNT_W(2), .GHR_W(0)) u_bim (
        .clk(clk), .rst(rst), .pcD(pcD), .branchD(branchD), .stallD(stallD),
        .pred_takeD(b_pred), .pred_ghrD(b_ghr), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred), .upd_ghr(upd_ghr[0:0]),
        .stat_branches(b_stat_br), .stat_mispred(b_stat_mp)
    );

    branch_predictor #(.PHT_IDX_W(6), .CNT_W(2), .GHR_W(4)) u_gsh (
        .clk(clk), .rst(rst), .pcD(pcD), .branchD(branchD), .stallD(stallD),
        .pred_takeD(g_pred), .pred_ghrD(g_ghr), .upd_en(upd_en), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_mispred(upd_mispred), .upd_ghr(upd_ghr),
        .stat_branches(g_stat_br), .stat_mispred(g_stat_mp)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drivers: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken,
                             input logic mispred, input logic [3:0] ghr);
        upd_en      = 1'b1;
        upd_pc      = pc;
        upd_taken   = taken;
        upd_mispred = mispred;
        upd_ghr     = ghr;
        tick();
        upd_en      = 1'b0;
        upd_mispred = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        pcD = 32'h100;
        branchD = 1'b1;
        #1;
        n_tests++; if (b_pred !== 1'b0) begin n_fail++; $display("FAIL reset_bim_pred got=%b exp=0", b_pred); end
        n_tests++; if (g_pred !== 1'b0) begin n_fail++; $display("FAIL reset_gsh_pred got=%b exp=0", g_pred); end
        n_tests++; if (b_stat_br !== 32'd0) begin n_fail++; $display("FAIL reset_stat_br got=%0d exp=0", b_stat_br); end
        n_tests++; if (b_stat_mp !== 32'd0) begin n_fail++; $display("FAIL reset_stat_mp got=%0d exp=0", b_stat_mp); end
        n_tests++; if (g_ghr !== 4'b0000) begin n_fail++; $display("FAIL reset_ghr got=%b exp=0000", g_ghr); end
        n_tests++; if (b_ghr !== 1'b0) begin n_fail++; $display("FAIL reset_bim_ghr got=%b exp=0", b_ghr); end
        branchD = 1'b0;
    endtask

    task automatic test_training();
        do_update(32'h100, 1'b1, 1'b0, 4'h0);
        do_update(32'h100, 1'b1, 1'b0, 4'h0);
        pcD = 32'h100;
        branchD = 1'b1;
        #1;
        n_tests++; if (b_pred !== 1'b1) begin n_fail++; $display("FAIL train_pred got=%b exp=1", b_pred); end
        n_tests++; if (b_stat_br !== 32'd2) begin n_fail++; $display("FAIL train_stat_br got=%0d exp=2", b_stat_br); end
        branchD = 1'b0;
    endtask

    task automatic test_saturation();
        pcD = 32'h100;
        for (int i = 0; i < 5; i++) do_update(32'h100, 1'b1, 1'b0, 4'h0);
        branchD = 1'b1;
        #1;
        n_tests++; if (b_pred !== 1'b1) begin n_fail++; $display("FAIL sat_high_pred got=%b exp=1", b_pred); end
        do_update(32'h100, 1'b0, 1'b0, 4'h0);
        #1;
        n_tests++; if (b_pred !== 1'b1) begin n_fail++; $display("FAIL sat_first_nt got=%b exp=1", b_pred); end
        do_update(32'h100, 1'b0, 1'b0, 4'h0);
        #1;
        n_tests++; if (b_pred !== 1'b0) begin n_fail++; $display("FAIL sat_second_nt got=%b exp=0", b_pred); end
        n_tests++; if (b_stat_br !== 32'd9) begin n_fail++; $display("FAIL sat_stat_br got=%0d exp=9", b_stat_br); end
        branchD = 1'b0;
    endtask

    task automatic test_aliasing();
        pcD = 32'h200;
        branchD = 1'b1;
        #1;
        n_tests++; if (b_pred !== 1'b0) begin n_fail++; $display("FAIL alias_before got=%b exp=0", b_pred); end
        branchD = 1'b0;
        do_update(32'h100, 1'b1, 1'b0, 4'h0);
        pcD = 32'h200;
        branchD = 1'b1;
        #1;
        n_tests++; if (b_pred !== 1'b1) begin n_fail++; $display("FAIL alias_after got=%b exp=1", b_pred); end
        pcD = 32'h104;
        #1;
        n_tests++; if (b_pred !== 1'b0) begin n_fail++; $display("FAIL alias_neighbor got=%b exp=0", b_pred); end
        branchD = 1'b0;
    endtask

    task automatic test_collision();
        pcD = 32'h100;
        branchD = 1'b1;
        upd_en = 1'b1;
        upd_pc = 32'h100;
        upd_taken = 1'b0;
        upd_mispred = 1'b0;
        upd_ghr = 4'h0;
        #1;
        n_tests++; if (b_pred !== 1'b1) begin n_fail++; $display("FAIL collide_same_cycle got=%b exp=1", b_pred); end
        tick();
        upd_en = 1'b0;
        #1;
        n_tests++; if (b_pred !== 1'b0) begin n_fail++; $display("FAIL collide_next_cycle got=%b exp=0", b_pred); end
        n_tests++; if (b_stat_br !== 32'd11) begin n_fail++; $display("FAIL collide_stat_br got=%0d exp=11", b_stat_br); end
        branchD = 1'b0;
    endtask

    task automatic test_reset_midop();
        rst = 1'b1;
        upd_en = 1'b1;
        upd_pc = 32'h100;
        upd_taken = 1'b1;
        upd_mispred = 1'b1;
        tick();
        rst = 1'b0;
        upd_en = 1'b0;
        upd_mispred = 1'b0;
        pcD = 32'h100;
        branchD = 1'b1;
        #1;
        n_tests++; if (b_stat_br !== 32'd0) begin n_fail++; $display("FAIL midrst_stat_br got=%0d exp=0", b_stat_br); end
        n_tests++; if (b_stat_mp !== 32'd0) begin n_fail++; $display("FAIL midrst_stat_mp got=%0d exp=0", b_stat_mp); end
        n_tests++; if (b_pred !== 1'b0) begin n_fail++; $display("FAIL midrst_pred got=%b exp=0", b_pred); end
        branchD = 1'b0;
    endtask

    task automatic test_gshare_history();
        do_update(32'h100, 1'b1, 1'b0, 4'h0);
        do_update(32'h100, 1'b1, 1'b0, 4'h0);
        do_update(32'h100, 1'b1, 1'b0, 4'h1);
        do_update(32'h100, 1'b1, 1'b0, 4'h1);
        do_update(32'h100, 1'b1, 1'b0, 4'h3);
        do_update(32'h100, 1'b1, 1'b0, 4'h3);
        pcD = 32'h100;
        branchD = 1'b1;
        stallD = 1'b0;
        #1;
        n_tests++; if (g_pred !== 1'b1) begin n_fail++; $display("FAIL hist_pred0 got=%b exp=1", g_pred); end
        tick();
        #1;
        n_tests++; if (g_ghr !== 4'b0001) begin n_fail++; $display("FAIL hist_ghr1 got=%b exp=0001", g_ghr); end
        n_tests++; if (g_pred !== 1'b1) begin n_fail++; $display("FAIL hist_pred1 got=%b exp=1", g_pred); end
        tick();
        #1;
        n_tests++; if (g_pred !== 1'b1) begin n_fail++; $display("FAIL hist_pred2 got=%b exp=1", g_pred); end
        tick();
        #1;
        n_tests++; if (g_ghr !== 4'b0111) begin n_fail++; $display("FAIL hist_ghr3 got=%b exp=0111", g_ghr); end
        stallD = 1'b1;
        tick();
        #1;
        n_tests++; if (g_ghr !== 4'b0111) begin n_fail++; $display("FAIL hist_stall got=%b exp=0111", g_ghr); end
        stallD = 1'b0;
        branchD = 1'b0;
    endtask

    task automatic test_repair();
        pcD = 32'h100;
        branchD = 1'b1;
        stallD = 1'b0;
        upd_en = 1'b1;
        upd_pc = 32'h100;
        upd_taken = 1'b0;
        upd_mispred = 1'b1;
        upd_ghr = 4'b0010;
        tick();
        upd_en = 1'b0;
        upd_mispred = 1'b0;
        branchD = 1'b0;
        #1;
        n_tests++; if (g_ghr !== 4'b0100) begin n_fail++; $display("FAIL repair_ghr got=%b exp=0100", g_ghr); end
        n_tests++; if (g_stat_mp !== 32'd1) begin n_fail++; $display("FAIL repair_stat_mp got=%0d exp=1", g_stat_mp); end
        n_tests++; if (g_stat_br !== 32'd7) begin n_fail++; $display("FAIL repair_stat_br got=%0d exp=7", g_stat_br); end
        upd_mispred = 1'b1;
        upd_ghr = 4'hF;
        upd_taken = 1'b1;
        tick();
        #1;
        n_tests++; if (g_ghr !== 4'b0100) begin n_fail++; $display("FAIL nomis_ghr got=%b exp=0100", g_ghr); end
        n_tests++; if (g_stat_mp !== 32'd1) begin n_fail++; $display("FAIL nomis_stat_mp got=%0d exp=1", g_stat_mp); end
        upd_mispred = 1'b0;
        branchD = 1'b1;
        #1;
        n_tests++; if (g_pred !== 1'b0) begin n_fail++; $display("FAIL shift_nt_pred got=%b exp=0", g_pred); end
        tick();
        #1;
        n_tests++; if (g_ghr !== 4'b1000) begin n_fail++; $display("FAIL shift_nt_ghr got=%b exp=1000", g_ghr); end
        n_tests++; if (b_ghr !== 1'b0) begin n_fail++; $display("FAIL bim_ghr_zero got=%b exp=0", b_ghr); end
        branchD = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        pcD = '0;
        branchD = 1'b0;
        stallD = 1'b0;
        upd_en = 1'b0;
        upd_pc = '0;
        upd_taken = 1'b0;
        upd_mispred = 1'b0;
        upd_ghr = '0;
        test_reset();
        test_training();
        test_saturation();
        test_aliasing();
        test_collision();
        test_reset_midop();
        test_gshare_history();
        test_repair();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter PHT_IDX_W, default 6: pattern-history-table index width; the table holds 2^PHT_IDX_W entries.
REQ-002 SHALL have parameter CNT_W, default 2: saturating-counter width, legal range 2..4.
REQ-003 SHALL have parameter GHR_W, default 0: global-history width; 0 selects bimodal mode, 1..PHT_IDX_W selects gshare mode.
REQ-004 SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have pcD, input, 32 bits: PC of the decode-stage instruction.
REQ-007 SHALL have branchD, input, 1 bit: the decode-stage instruction is a conditional branch.
REQ-008 SHALL have stallD, input, 1 bit: decode stage is held this cycle.
REQ-009 SHALL have pred_takeD, output, 1 bit: taken prediction for the decode-stage branch.
REQ-010 SHALL have pred_ghrD, output, max(GHR_W,1) bits: GHR checkpoint that the pipeline carries with the branch.
REQ-011 SHALL have upd_en, input, 1 bit: a resolved branch is reported this cycle.
REQ-012 SHALL have upd_pc, input, 32 bits: PC of the resolved branch.
REQ-013 SHALL have upd_taken, input, 1 bit: actual outcome of the resolved branch.
REQ-014 SHALL have upd_mispred, input, 1 bit: the resolved branch was mispredicted.
REQ-015 SHALL have upd_ghr, input, max(GHR_W,1) bits: checkpoint returned with the resolved branch.
REQ-016 SHALL have stat_branches, output, 32 bits: count of resolved branches.
REQ-017 SHALL have stat_mispred, output, 32 bits: count of mispredicted branches.

Function
REQ-018 SHALL compute the lookup index as pcD[PHT_IDX_W+1:2] XOR {zero-pad, ghr} in gshare mode, and as pcD[PHT_IDX_W+1:2] alone in bimodal mode.
REQ-019 SHALL compute the update index the same way from upd_pc and upd_ghr.
REQ-020 SHALL drive pred_takeD combinationally as the MSB of the indexed counter when branchD=1, and 0 when branchD=0.
REQ-021 SHALL drive pred_ghrD combinationally as the current GHR; in bimodal mode it SHALL be 0.
REQ-022 SHALL, on upd_en=1, increment the indexed counter if upd_taken=1 and decrement it otherwise, saturating at 2^CNT_W-1 and at 0.
REQ-023 SHALL make a lookup and an update to the same index in the same cycle see the pre-update counter value; the write lands at the clock edge.
REQ-024 SHALL, in gshare mode with branchD=1, stallD=0 and no concurrent repair, shift the GHR left and insert pred_takeD at bit 0.
REQ-025 SHALL hold the GHR while stallD=1.
REQ-026 SHALL, on upd_en=1 and upd_mispred=1, load GHR = {upd_ghr[GHR_W-2:0], upd_taken}.
REQ-027 SHALL give the repair of REQ-026 priority over a speculative shift in the same cycle.
REQ-028 SHALL increment stat_branches on each upd_en=1 cycle.
REQ-029 SHALL increment stat_mispred on each cycle with upd_en=1 and upd_mispred=1.
REQ-030 SHALL saturate both statistics counters at 32'hFFFFFFFF and never wrap.
REQ-031 SHALL ignore upd_mispred when upd_en=0.
REQ-032 SHALL ignore upd_en and branchD while rst=1.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, set every counter to weakly-not-taken (2^(CNT_W-1)-1), GHR to 0, and both statistics counters to 0.
REQ-034 SHALL drive pred_takeD=0 for any PC in the cycle after reset.
REQ-035 SHALL let reset asserted mid-operation discard any update presented in the same cycle.

Verification
REQ-036 SHALL cover reset then training: after rst, CNT_W=2, pcD=0x100 with branchD=1 -> pred_takeD=0; two upd_en, upd_taken=1 at upd_pc=0x100 -> pred_takeD=1; stat_branches=2.
REQ-037 SHALL cover saturation: five taken updates then one not-taken at 0x100 -> counter 3 then 2, pred_takeD stays 1; one more not-taken -> counter 1, pred_takeD=0.
REQ-038 SHALL cover aliasing in bimodal mode with PHT_IDX_W=6: updates at 0x100 -> prediction at 0x200 reflects the same entry.
REQ-039 SHALL cover gshare history with GHR_W=4: three unstalled predicted-taken branches -> pred_ghrD=4'b0111; a repeat with stallD=1 -> GHR unchanged.
REQ-040 SHALL cover repair priority: GHR=4'b0111, branchD=1, stallD=0 with upd_en=1, upd_mispred=1, upd_ghr=4'b0010, upd_taken=0 in the same cycle -> next GHR=4'b0100; stat_mispred increments by 1.
REQ-041 SHALL cover same-index collision: lookup and not-taken update to the same index in one cycle from counter 2 -> pred_takeD=1 that cycle, 0 the next.
